// File: rtl/inst_ram_loader_if.sv
// Byte-stream and inst_ram port-A bundle for the instruction RAM loader.
// The loader uses the slave modport: it takes bytes in and drives the RAM write port.
// The master modport is the byte source side, which can also observe the RAM writes.
interface inst_ram_loader_if #(
   parameter int ADDR_W = 8
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              ram_ena;
   logic [3:0]        ram_wea;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, ram_ena, ram_wea, ram_addr, ram_din
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, ram_ena, ram_wea, ram_addr, ram_din
   );
endinterface

// File: rtl/inst_ram_loader.sv
// Instruction RAM loader: packs a byte stream little-endian into 32-bit words,
// writes them to inst_ram port A from word 0 upward, and keeps the core in
// reset until the whole image has been written.
module inst_ram_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_words,
   input  logic              load_abort,
   inst_ram_loader_if.slave  bus,
   output logic              core_hold,
   output logic              load_busy,
   output logic              load_done,
   output logic              err_len
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   // Capacity expressed in the width of load_words so the length check is width-matched.
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t            state_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   wcnt_q;
   logic [ADDR_W:0]   wcnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        lane_q;
   logic [23:0]       word_q;
   logic              ram_ena_q;
   logic [3:0]        ram_wea_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [31:0]       ram_din_q;
   logic              hold_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;

   // Word count after the write in progress retires; decides DONE vs. next word.
   assign wcnt_d = wcnt_q + (ADDR_W+1)'(1);

   // Only the ready flag is decoded combinationally; everything else is registered.
   assign bus.byte_ready = (state_q == LOAD);
   assign bus.ram_ena    = ram_ena_q;
   assign bus.ram_wea    = ram_wea_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_din    = ram_din_q;
   assign core_hold      = hold_q;
   assign load_busy      = busy_q;
   assign load_done      = done_q;
   assign err_len        = err_q;

   // Loader FSM with byte packing, RAM write strobes and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         len_q      <= '0;
         wcnt_q     <= '0;
         addr_q     <= '0;
         lane_q     <= '0;
         word_q     <= '0;
         ram_ena_q  <= 1'b0;
         ram_wea_q  <= 4'h0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         hold_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         // Write strobes are single-cycle; only the entry into WRITE raises them.
         ram_ena_q <= 1'b0;
         ram_wea_q <= 4'h0;
         case (state_q)
            IDLE, DONE: begin
               if (load_start) begin
                  if (load_words > DEPTH_W) begin
                     // Oversized image: flag it and leave the core and state alone.
                     err_q <= 1'b1;
                  end else if (load_words == '0) begin
                     // Empty image: nothing to write, release the core right away.
                     err_q   <= 1'b0;
                     state_q <= DONE;
                     hold_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     len_q   <= load_words;
                     wcnt_q  <= '0;
                     lane_q  <= '0;
                     addr_q  <= '0;
                     err_q   <= 1'b0;
                     done_q  <= 1'b0;
                     hold_q  <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (load_abort) begin
                  // Partial word is dropped; the core stays held.
                  lane_q  <= '0;
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (bus.byte_valid) begin
                  lane_q <= lane_q + 2'd1;
                  case (lane_q)
                     2'd0: word_q[7:0]   <= bus.byte_data;
                     2'd1: word_q[15:8]  <= bus.byte_data;
                     2'd2: word_q[23:16] <= bus.byte_data;
                     default: begin
                        // Last lane goes straight into the RAM data register.
                        ram_ena_q  <= 1'b1;
                        ram_wea_q  <= 4'hF;
                        ram_addr_q <= addr_q;
                        ram_din_q  <= {bus.byte_data, word_q};
                        state_q    <= WRITE;
                     end
                  endcase
               end
            end
            WRITE: begin
               // The write strobe is active this cycle whatever happens next.
               addr_q <= addr_q + ADDR_W'(1);
               wcnt_q <= wcnt_d;
               if (load_abort) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else if (wcnt_d == len_q) begin
                  busy_q  <= 1'b0;
                  hold_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= LOAD;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_ram_loader.sv
// Self-checking bench for inst_ram_loader: control-vector table, directed
// multi-cycle sequences and randomized loads against a packing model.
module tb_inst_ram_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load_start = 1'b0;
   logic [ADDR_W:0]   load_words = '0;
   logic              load_abort = 1'b0;
   logic              core_hold;
   logic              load_busy;
   logic              load_done;
   logic              err_len;

   inst_ram_loader_if #(.ADDR_W(ADDR_W)) bus();

   inst_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .load_words (load_words),
      .load_abort (load_abort),
      .bus        (bus.slave),
      .core_hold  (core_hold),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .err_len    (err_len)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [31:0]       wr_data_q[$];
   logic [7:0]        bq[$];

   typedef struct {
      logic            start;
      logic            abort;
      logic [ADDR_W:0] words;
      logic            e_err;
      logic            e_done;
      logic            e_hold;
      logic            e_busy;
      logic            e_ready;
   } vec_t;

   vec_t tv[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Capture every RAM write in the middle of its cycle.
   always @(negedge clk) begin
      if (bus.ram_ena === 1'b1) begin
         wr_addr_q.push_back(bus.ram_addr);
         wr_data_q.push_back(bus.ram_din);
         check("wea during write", 32'(bus.ram_wea), 32'h0000000F);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      bq.delete();
   endtask

   task automatic start_load(input int n);
      load_words = (ADDR_W+1)'(n);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; returns right after the transfer edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      bus.byte_valid = 1'b0;
      repeat (gap) tick();
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      w = 0;
      while (bus.byte_ready !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      if (bus.byte_ready !== 1'b1) begin
         check("byte_ready timeout", 32'(bus.byte_ready), 32'd1);
         bus.byte_valid = 1'b0;
      end else begin
         tick();
         bus.byte_valid = 1'b0;
         bq.push_back(b);
      end
   endtask

   task automatic wait_done(input int budget);
      int c;
      c = 0;
      while (load_done !== 1'b1 && c < budget) begin
         tick();
         c++;
      end
      check("load_done reached", 32'(load_done), 32'd1);
   endtask

   // Reference: word i is bytes 4i..4i+3 little-endian, written to address i.
   task automatic check_writes(input string name, input int nw);
      logic [31:0] exp;
      check({name, " write count"}, 32'(wr_addr_q.size()), 32'(nw));
      for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
         exp = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
         check($sformatf("%s addr[%0d]", name, i), 32'(wr_addr_q[i]), 32'(i));
         check($sformatf("%s data[%0d]", name, i), wr_data_q[i], exp);
      end
   endtask

   task automatic check_flags(input string name, input logic e_hold, input logic e_busy,
                              input logic e_done);
      check({name, " core_hold"}, 32'(core_hold), 32'(e_hold));
      check({name, " load_busy"}, 32'(load_busy), 32'(e_busy));
      check({name, " load_done"}, 32'(load_done), 32'(e_done));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, k, gap;
      logic do_abort;
      logic [7:0] b;

      //               start abort words    err   done  hold  busy  ready
      tv[0] = '{1'b1, 1'b0, 9'd257, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[1] = '{1'b1, 1'b0, 9'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[2] = '{1'b1, 1'b0, 9'd511, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[3] = '{1'b1, 1'b0, 9'd256, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tv[4] = '{1'b1, 1'b0, 9'd1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tv[5] = '{1'b1, 1'b1, 9'd1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[6] = '{1'b0, 1'b1, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[7] = '{1'b1, 1'b1, 9'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[8] = '{1'b1, 1'b0, 9'd2,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tv[9] = '{1'b0, 1'b1, 9'd0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;

      // Reset state
      #12;
      check("reset core_hold", 32'(core_hold), 32'd1);
      check("reset byte_ready", 32'(bus.byte_ready), 32'd0);
      check("reset ram_ena", 32'(bus.ram_ena), 32'd0);
      check("reset ram_wea", 32'(bus.ram_wea), 32'd0);
      check("reset ram_addr", 32'(bus.ram_addr), 32'd0);
      check("reset ram_din", bus.ram_din, 32'd0);
      check("reset err_len", 32'(err_len), 32'd0);
      check_flags("reset", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Control vectors
      for (int i = 0; i < 10; i++) begin
         load_start = tv[i].start;
         load_abort = tv[i].abort;
         load_words = tv[i].words;
         tick();
         load_start = 1'b0;
         load_abort = 1'b0;
         check($sformatf("vec%0d err_len", i), 32'(err_len), 32'(tv[i].e_err));
         check($sformatf("vec%0d byte_ready", i), 32'(bus.byte_ready), 32'(tv[i].e_ready));
         check_flags($sformatf("vec%0d", i), tv[i].e_hold, tv[i].e_busy, tv[i].e_done);
      end
      check("vec no writes", 32'(wr_addr_q.size()), 32'd0);

      // Single word, back-to-back bytes
      clear_log();
      start_load(1);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      send_byte(8'h50, 0);
      send_byte(8'h00, 0);
      check("single ram_ena", 32'(bus.ram_ena), 32'd1);
      check("single ram_wea", 32'(bus.ram_wea), 32'hF);
      check("single ram_addr", 32'(bus.ram_addr), 32'd0);
      check("single ram_din", bus.ram_din, 32'h00500513);
      check("single hold during write", 32'(core_hold), 32'd1);
      tick();
      check_flags("single after", 1'b0, 1'b0, 1'b1);
      check("single byte_ready after", 32'(bus.byte_ready), 32'd0);
      check("single ram_ena after", 32'(bus.ram_ena), 32'd0);
      check_writes("single", 1);

      // Three words with byte_valid toggling
      clear_log();
      start_load(3);
      for (int i = 0; i < 12; i++) send_byte(8'(8'hA0 + 8'(i * 7)), 1);
      check("three done before last write", 32'(load_done), 32'd0);
      tick();
      check_flags("three after", 1'b0, 1'b0, 1'b1);
      check_writes("three", 3);

      // Abort mid-load, then restart from address 0
      clear_log();
      start_load(2);
      for (int i = 0; i < 5; i++) send_byte(8'(8'h31 + 8'(i)), 0);
      load_abort = 1'b1;
      tick();
      load_abort = 1'b0;
      check_flags("abort", 1'b1, 1'b0, 1'b0);
      check("abort byte_ready", 32'(bus.byte_ready), 32'd0);
      tick();
      tick();
      check_writes("abort", 1);
      clear_log();
      start_load(1);
      for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + 8'(i)), 0);
      wait_done(4);
      tick();
      check_writes("restart", 1);

      // Reload from DONE
      clear_log();
      start_load(2);
      check_flags("reload start", 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'(8'h5A ^ 8'(i * 13)), 0);
      wait_done(4);
      check("reload core_hold", 32'(core_hold), 32'd0);
      tick();
      check_writes("reload", 2);

      // Asynchronous reset mid-stream discards lane/word progress
      start_load(3);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h77 + 8'(i)), 0);
      #2;
      rst = 1'b0;
      #1;
      check("midrst core_hold", 32'(core_hold), 32'd1);
      check("midrst byte_ready", 32'(bus.byte_ready), 32'd0);
      check("midrst ram_ena", 32'(bus.ram_ena), 32'd0);
      check("midrst ram_din", bus.ram_din, 32'd0);
      check("midrst err_len", 32'(err_len), 32'd0);
      check_flags("midrst", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      clear_log();
      start_load(1);
      for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + 8'(i)), 0);
      wait_done(4);
      tick();
      check_writes("after midrst", 1);

      // Randomized loads, some aborted, against the packing model
      for (int it = 0; it < 30; it++) begin
         n = ($urandom_range(0, 4) == 0) ? $urandom_range(7, 24) : $urandom_range(1, 6);
         do_abort = ($urandom_range(0, 3) == 0);
         k = do_abort ? $urandom_range(1, 4 * n - 1) : 4 * n;
         clear_log();
         start_load(n);
         for (int i = 0; i < k; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 2);
            send_byte(b, gap);
         end
         if (do_abort) begin
            load_abort = 1'b1;
            tick();
            load_abort = 1'b0;
            tick();
            check_flags($sformatf("rand%0d abort", it), 1'b1, 1'b0, 1'b0);
            check_writes($sformatf("rand%0d", it), k / 4);
         end else begin
            wait_done(4);
            check($sformatf("rand%0d core_hold", it), 32'(core_hold), 32'd0);
            tick();
            check_writes($sformatf("rand%0d", it), n);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_ram_loader.md
Name: inst_ram_loader

Overview:
- Write-side counterpart of the core's read-only instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes the words sequentially into inst_ram port A from word address 0.
- Holds the RISC-V core in reset until the program image is complete, then releases it.

Parameters:
- ADDR_W, 8, inst_ram word-address width (matches the 8-bit addra).
- DEPTH, 256, inst_ram capacity in words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse; begins a load in IDLE or DONE.
- load_words  in  ADDR_W+1  image length in words; sampled on load_start.
- load_abort  in  1  abandons the load in progress.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  next image byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- ram_ena  out  1  inst_ram ena during load writes.
- ram_wea  out  4  inst_ram wea.
- ram_addr  out  ADDR_W  inst_ram addra (word address).
- ram_din  out  32  inst_ram dina.
- core_hold  out  1  1 = core held in reset; top ORs this into the core reset.
- load_busy  out  1  state is LOAD or WRITE.
- load_done  out  1  last load completed.
- err_len  out  1  last load_start was rejected (load_words > DEPTH).

Behaviour:
- States: IDLE, LOAD, WRITE, DONE. All outputs are registered except byte_ready, which is decoded from state.
- Reset (asynchronous, rst=0):
  - State goes to IDLE.
  - core_hold=1; byte_ready=0; ram_ena=0; ram_wea=0; ram_addr=0; ram_din=0.
  - load_busy=0, load_done=0, err_len=0.
  - Lane counter, word counter and word assembler are cleared.
  - Reset mid-load discards all progress. Words already written stay in the RAM.
- Byte transfer happens on a posedge where byte_valid & byte_ready are both 1.
- byte_ready=1 only in LOAD.
- Packing:
  - Lane counter runs 0..3; byte k lands in bits [8k+7:8k].
  - The first byte of the stream is bits [7:0] of word 0.
- IDLE / DONE, on load_start:
  - If load_words > DEPTH: err_len<=1, state unchanged, core_hold unchanged.
  - Else if load_words == 0: err_len<=0, go to DONE, core_hold<=0, load_done<=1.
  - Otherwise:
    - Latch load_words; clear word counter, lane counter and address.
    - err_len<=0, load_done<=0, core_hold<=1.
    - Go to LOAD.
- LOAD: on the 4th accepted byte (lane 3), go to WRITE.
- WRITE (exactly one cycle):
  - Drive ram_ena=1, ram_wea=4'hF, ram_addr = current word address, ram_din = assembled word.
  - On exit: address +1 and word counter +1.
  - If the word counter now equals the latched length: go to DONE, core_hold<=0, load_done<=1.
  - Otherwise return to LOAD.
  - ram_ena/ram_wea are 0 in every other state.
- Addressing and throughput:
  - Address width is ADDR_W and never wraps, because the length is capped at DEPTH.
  - Peak throughput is 4 bytes per 5 cycles.
- load_abort:
  - In LOAD: go to IDLE, discard the partial word, core_hold stays 1, load_done=0.
  - In WRITE: the write still completes, then go to IDLE.
  - In IDLE or DONE: ignored.
  - If load_abort and load_start arrive in the same cycle, load_abort wins when busy. In IDLE/DONE, load_start is processed.
- load_start while busy is ignored.
- byte_valid outside LOAD is ignored: no transfer, no state change.
- load_busy = (state is LOAD or WRITE), registered alongside the state.

Test Plan:
- Reset: rst=0 mid-stream, then 1 -> core_hold=1, byte_ready=0, ram_ena=0, all flags 0, state IDLE.
- Single word:
  - Stimulus: load_start with load_words=1, then bytes 0x13,0x05,0x50,0x00 sent back-to-back.
  - Required response: one cycle with ram_ena=1, wea=4'hF, addr=0, din=32'h00500513.
  - The next cycle: core_hold=0, load_done=1, byte_ready=0.
- Three words with byte_valid toggling every other cycle -> writes to addr 0,1,2 with the correct packed data; no write while byte_valid is 0; done after the 12th byte's WRITE.
- Length checks:
  - load_words=257 -> err_len=1, state stays IDLE, core_hold=1.
  - A following load_words=0 -> DONE, core_hold=0, err_len=0.
- Abort:
  - Stimulus: load_words=2, 5 bytes sent, then load_abort.
  - Required response: exactly one write (addr 0), state IDLE, core_hold=1, load_done=0.
  - A restart rewrites from addr 0.
- Reload from DONE: load_start -> core_hold returns to 1 on the next cycle, load_done=0, and the load completes normally.
